// File: rtl/ila_capture_core_pkg.sv
// rtl/ila_capture_core_pkg.sv - shared FSM encodings and readout select width for the ILA capture core
// Contents:
//   ila_state_e : capture FSM states (IDLE=0, ARMED=1, POST=2, DONE=3)
//   sel_width() : width of the readout word-select port, max(1, clog2(SIGNAL_W/DATA_W))
package ila_capture_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } ila_state_e;

  function automatic int sel_width(input int signal_w, input int data_w);
    int w;
    w = $clog2(signal_w / data_w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ila_trig_cell.sv
// rtl/ila_trig_cell.sv - one trigger input: negate, level/rising-edge detect and mask
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous clear of the edge history
//   sample_en     : sample strobe; the edge history only advances on sampled cycles
//   trig_in       : raw trigger input
//   mask          : 1 = this trigger takes part in the reduction
//   negate        : 1 = invert the trigger before detection
//   edge_mode     : 1 = rising edge, 0 = level
//   or_term       : contribution to an OR reduction (0 when masked out)
//   and_term      : contribution to an AND reduction (1 when masked out)
module ila_trig_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sample_en,
  input  logic trig_in,
  input  logic mask,
  input  logic negate,
  input  logic edge_mode,
  output logic or_term,
  output logic and_term
);

  logic t;
  logic hit;
  logic t_prev_d;
  logic t_prev_q;

  always_comb begin
    t        = trig_in ^ negate;
    hit      = edge_mode ? (t & ~t_prev_q) : t;
    t_prev_d = t_prev_q;
    if (clr) begin
      t_prev_d = 1'b0;
    end else if (sample_en) begin
      t_prev_d = t;
    end
    // Masked-out cells are neutral for either reduction.
    or_term  = mask & hit;
    and_term = ~mask | hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_prev_q <= 1'b0;
    end else begin
      t_prev_q <= t_prev_d;
    end
  end

endmodule

// File: rtl/ila_capture_core.sv
// rtl/ila_capture_core.sv - integrated logic analyser capture core with pre/post trigger window
// Optional feature macro: ILA_PRETRIGGER_EN (when undefined, pretrig_cnt is ignored and treated as 0).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   soft_rst                 : synchronous clear, wins over arm
//   sample_en, signal        : sample strobe and probed data
//   trigger, trig_mask, trig_negate, trig_edge, reduce_and : trigger inputs and their configuration
//   arm                      : start a new capture
//   pretrig_cnt, posttrig_cnt: samples kept before / after the trigger sample
//   rd_index, rd_sel         : readout index (0 = oldest) and word select
//   rd_data                  : registered readout word, one cycle after rd_index/rd_sel
//   state, n_samples, trig_pos : FSM state, captured sample count, trigger index within capture
module ila_capture_core
  import ila_capture_core_pkg::*;
#(
  parameter int SIGNAL_W  = 64,
  parameter int DATA_W    = 32,
  parameter int BUFFER_W  = 10,
  parameter int TRIGGER_W = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    soft_rst,
  input  logic                                    sample_en,
  input  logic [SIGNAL_W-1:0]                     signal,
  input  logic [TRIGGER_W-1:0]                    trigger,
  input  logic [TRIGGER_W-1:0]                    trig_mask,
  input  logic [TRIGGER_W-1:0]                    trig_negate,
  input  logic [TRIGGER_W-1:0]                    trig_edge,
  input  logic                                    reduce_and,
  input  logic                                    arm,
  input  logic [BUFFER_W-1:0]                     pretrig_cnt,
  input  logic [BUFFER_W-1:0]                     posttrig_cnt,
  input  logic [BUFFER_W-1:0]                     rd_index,
  input  logic [sel_width(SIGNAL_W, DATA_W)-1:0]  rd_sel,
  output logic [DATA_W-1:0]                       rd_data,
  output logic [1:0]                              state,
  output logic [BUFFER_W:0]                       n_samples,
  output logic [BUFFER_W-1:0]                     trig_pos
);

  localparam int DEPTH = 1 << BUFFER_W;
  localparam int WORDS = SIGNAL_W / DATA_W;
  localparam int SEL_W = sel_width(SIGNAL_W, DATA_W);

  // ---------------------------------------------------------------- triggers
  logic [TRIGGER_W-1:0] or_terms;
  logic [TRIGGER_W-1:0] and_terms;
  logic                 trig_fire;

  for (genvar i = 0; i < TRIGGER_W; i++) begin : g_trig
    ila_trig_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .clr       (soft_rst),
      .sample_en (sample_en),
      .trig_in   (trigger[i]),
      .mask      (trig_mask[i]),
      .negate    (trig_negate[i]),
      .edge_mode (trig_edge[i]),
      .or_term   (or_terms[i]),
      .and_term  (and_terms[i])
    );
  end

  // AND needs at least one enabled trigger, otherwise an all-masked set would fire.
  assign trig_fire = reduce_and ? ((|trig_mask) & (&and_terms)) : (|or_terms);

  // ----------------------------------------------------------- window sizes
  logic [BUFFER_W-1:0] pre_eff;
  logic [BUFFER_W-1:0] post_room;
  logic [BUFFER_W-1:0] post_eff;

`ifdef ILA_PRETRIGGER_EN
  assign pre_eff = pretrig_cnt;
`else
  logic unused_pretrig;
  assign unused_pretrig = ^pretrig_cnt;
  assign pre_eff        = '0;
`endif

  // The whole window must fit in the buffer: pre + 1 + post <= depth.
  assign post_room = {BUFFER_W{1'b1}} - pre_eff;
  assign post_eff  = (posttrig_cnt < post_room) ? posttrig_cnt : post_room;

  // ------------------------------------------------------------- capture FSM
  ila_state_e          state_d,     state_q;
  logic [BUFFER_W-1:0] wr_ptr_d,    wr_ptr_q;
  logic [BUFFER_W-1:0] fill_d,      fill_q;
  logic [BUFFER_W-1:0] post_d,      post_q;
  logic [BUFFER_W:0]   n_samples_d, n_samples_q;
  logic [BUFFER_W-1:0] trig_pos_d,  trig_pos_q;
  logic [BUFFER_W-1:0] oldest_d,    oldest_q;
  logic                mem_we;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_d      = post_q;
    n_samples_d = n_samples_q;
    trig_pos_d  = trig_pos_q;
    oldest_d    = oldest_q;
    mem_we      = 1'b0;
    if (soft_rst) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      fill_d      = '0;
      post_d      = '0;
      n_samples_d = '0;
      trig_pos_d  = '0;
      oldest_d    = '0;
    end else if (arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      fill_d      = '0;
      post_d      = '0;
      n_samples_d = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sample_en) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (trig_fire && (fill_q >= pre_eff)) begin
              // The trigger sample is stored this cycle; the window starts fill_q samples back.
              state_d     = ST_POST;
              trig_pos_d  = fill_q;
              oldest_d    = wr_ptr_q - fill_q;
              n_samples_d = {1'b0, fill_q} + 1'b1;
            end else if (fill_q < pre_eff) begin
              fill_d = fill_q + 1'b1;
            end
          end
        end
        ST_POST: begin
          if (post_q >= post_eff) begin
            state_d = ST_DONE;
          end else if (sample_en) begin
            mem_we      = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            post_d      = post_q + 1'b1;
            n_samples_d = n_samples_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_q      <= '0;
      n_samples_q <= '0;
      trig_pos_q  <= '0;
      oldest_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_q      <= post_d;
      n_samples_q <= n_samples_d;
      trig_pos_q  <= trig_pos_d;
      oldest_q    <= oldest_d;
    end
  end

  // ------------------------------------------------------ buffer and readout
  logic [SIGNAL_W-1:0] mem [DEPTH];

  // Capture buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= signal;
    end
  end

  logic [BUFFER_W-1:0] rd_addr;
  logic [SIGNAL_W-1:0] rd_line;
  logic [DATA_W-1:0]   rd_data_d, rd_data_q;

  always_comb begin
    rd_addr   = oldest_q + rd_index;
    rd_line   = mem[rd_addr];
    rd_data_d = rd_line[DATA_W-1:0];
    for (int w = 1; w < WORDS; w++) begin
      if (rd_sel == SEL_W'(w)) begin
        rd_data_d = rd_line[w*DATA_W +: DATA_W];
      end
    end
    if (soft_rst) begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign state     = state_q;
  assign n_samples = n_samples_q;
  assign trig_pos  = trig_pos_q;

endmodule
